// File: rtl/regfile_port_sequencer.sv
// Round-robin sequencer for the shared register-file write port, with an optional
// byte read-modify-write path through read port 2 (enabled by `REGSEQ_BYTE_RMW_EN`).
module regfile_port_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_reg,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_byte,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_reg,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_byte,
   output logic [ADDR_W-1:0] rf_read_reg,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_regWrite,
   output logic              busy,
   output logic [CNT_W-1:0]  wr_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_e;

`ifdef REGSEQ_BYTE_RMW_EN
   localparam bit RMW_EN = 1'b1;
`else
   localparam bit RMW_EN = 1'b0;
`endif

   // Low byte from the request, upper bits from base (zero for a plain byte write).
   function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] base,
                                                    input logic [7:0]        lsb);
      return {base[DATA_W-1:8], lsb};
   endfunction

   state_e              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                we_q, we_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                gnt0_s, gnt1_s, hs_s;
   logic [ADDR_W-1:0]   sel_reg_s;
   logic [DATA_W-1:0]   sel_data_s;
   logic                sel_byte_s;

`ifdef REGSEQ_BYTE_RMW_EN
   logic [ADDR_W-1:0]   lat_reg_q, lat_reg_d;
   logic [7:0]          lat_byte_q, lat_byte_d;
   logic [ADDR_W-1:0]   rd_reg_q, rd_reg_d;
   logic                unused_rd_lsb_s;
   assign unused_rd_lsb_s = ^rf_read_data[7:0];
`else
   logic                unused_rd_data_s;
   assign unused_rd_data_s = ^rf_read_data;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (hs_s) begin
               state_d = (sel_byte_s && RMW_EN) ? READ : WRITE;
            end else begin
               state_d = IDLE;
            end
         end
`ifdef REGSEQ_BYTE_RMW_EN
         READ:    state_d = WRITE;
`endif
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant outputs: only in IDLE, ties go to the requester not granted last.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (reset_n && (state_q == IDLE)) begin
         gnt0_s = req0_valid && (!req1_valid || last_grant_q);
         gnt1_s = req1_valid && (!req0_valid || !last_grant_q);
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   assign hs_s       = gnt0_s | gnt1_s;
   assign sel_reg_s  = gnt1_s ? req1_reg  : req0_reg;
   assign sel_data_s = gnt1_s ? req1_data : req0_data;
   assign sel_byte_s = gnt1_s ? req1_byte : req0_byte;

   // Datapath next-state: latch on handshake, load the write port on entry to WRITE.
   always_comb begin
      last_grant_d = last_grant_q;
      wr_reg_d     = wr_reg_q;
      wr_data_d    = wr_data_q;
      we_d         = 1'b0;
      cnt_d        = we_q ? (cnt_q + CNT_W'(1)) : cnt_q;
`ifdef REGSEQ_BYTE_RMW_EN
      lat_reg_d    = lat_reg_q;
      lat_byte_d   = lat_byte_q;
      rd_reg_d     = {ADDR_W{1'b0}};
`endif
      case (state_q)
         IDLE: begin
            if (hs_s) begin
               last_grant_d = gnt1_s;
`ifdef REGSEQ_BYTE_RMW_EN
               lat_reg_d    = sel_reg_s;
               lat_byte_d   = sel_data_s[7:0];
`endif
               if (state_d == WRITE) begin
                  wr_reg_d  = sel_reg_s;
                  wr_data_d = sel_byte_s ? byte_merge({DATA_W{1'b0}}, sel_data_s[7:0])
                                         : sel_data_s;
                  we_d      = (sel_reg_s != {ADDR_W{1'b0}});
               end else begin
`ifdef REGSEQ_BYTE_RMW_EN
                  rd_reg_d  = sel_reg_s;
`endif
                  we_d      = 1'b0;
               end
            end else begin
               last_grant_d = last_grant_q;
            end
         end
`ifdef REGSEQ_BYTE_RMW_EN
         READ: begin
            wr_reg_d  = lat_reg_q;
            wr_data_d = byte_merge(rf_read_data, lat_byte_q);
            we_d      = (lat_reg_q != {ADDR_W{1'b0}});
         end
`endif
         WRITE:   we_d = 1'b0;
         default: we_d = 1'b0;
      endcase
   end

   // Datapath and output registers; a reset mid-sequence drops the in-flight write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= 1'b1;
         wr_reg_q     <= {ADDR_W{1'b0}};
         wr_data_q    <= {DATA_W{1'b0}};
         we_q         <= 1'b0;
         cnt_q        <= {CNT_W{1'b0}};
`ifdef REGSEQ_BYTE_RMW_EN
         lat_reg_q    <= {ADDR_W{1'b0}};
         lat_byte_q   <= 8'h00;
         rd_reg_q     <= {ADDR_W{1'b0}};
`endif
      end else begin
         last_grant_q <= last_grant_d;
         wr_reg_q     <= wr_reg_d;
         wr_data_q    <= wr_data_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
`ifdef REGSEQ_BYTE_RMW_EN
         lat_reg_q    <= lat_reg_d;
         lat_byte_q   <= lat_byte_d;
         rd_reg_q     <= rd_reg_d;
`endif
      end
   end

   assign req0_ready    = gnt0_s;
   assign req1_ready    = gnt1_s;
   assign rf_write_reg  = wr_reg_q;
   assign rf_write_data = wr_data_q;
   assign rf_regWrite   = we_q;
   assign busy          = (state_q != IDLE);
   assign wr_count      = cnt_q;
`ifdef REGSEQ_BYTE_RMW_EN
   assign rf_read_reg   = rd_reg_q;
`else
   assign rf_read_reg   = {ADDR_W{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench for regfile_port_sequencer (CNT_W=4) with a behavioural register-block model.
module tb_regfile_port_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req0_valid, req0_ready, req0_byte;
   logic [4:0]  req0_reg;
   logic [31:0] req0_data;
   logic        req1_valid, req1_ready, req1_byte;
   logic [4:0]  req1_reg;
   logic [31:0] req1_data;
   logic [4:0]  rf_read_reg, rf_write_reg;
   logic [31:0] rf_read_data, rf_write_data;
   logic        rf_regWrite, busy;
   logic [3:0]  wr_count;

   logic [31:0] regs [32];
   logic        mdl_clr;
   int          n_vec = 0;
   int          n_err = 0;
   int          g;

   always #5 clk = ~clk;

   regfile_port_sequencer #(.ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg),
      .req0_data(req0_data), .req0_byte(req0_byte),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg),
      .req1_data(req1_data), .req1_byte(req1_byte),
      .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
      .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
      .rf_regWrite(rf_regWrite), .busy(busy), .wr_count(wr_count)
   );

   // Register block model: combinational read, write on the strobe.
   assign rf_read_data = regs[rf_read_reg];
   always @(posedge clk) begin
      if (mdl_clr) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
         regs[7] <= 32'h1234_5678;
      end else if (rf_regWrite) begin
         regs[rf_write_reg] <= rf_write_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #1;
      reset_n    = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; mdl_clr = 1'b1;
      req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEAD_BEEF; req0_byte = 1'b0;
      req1_valid = 1'b0; req1_reg = 5'd0; req1_data = 32'd0;         req1_byte = 1'b0;
      step(); step();
      @(negedge clk);
      check_eq("rst_rdy0", {31'd0, req0_ready}, 32'd0);
      check_eq("rst_rdy1", {31'd0, req1_ready}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_we", {31'd0, rf_regWrite}, 32'd0);
      check_eq("rst_wreg", {27'd0, rf_write_reg}, 32'd0);
      check_eq("rst_wdata", rf_write_data, 32'd0);
      check_eq("rst_rreg", {27'd0, rf_read_reg}, 32'd0);
      check_eq("rst_cnt", {28'd0, wr_count}, 32'd0);

      // Word write of 0xDEADBEEF to r5 by req0.
      @(posedge clk); #1;
      reset_n = 1'b1; mdl_clr = 1'b0;
      @(negedge clk);
      check_eq("w_rdy0", {31'd0, req0_ready}, 32'd1);
      check_eq("w_rdy1", {31'd0, req1_ready}, 32'd0);
      step(); req0_valid = 1'b0;
      @(negedge clk);
      check_eq("w_we", {31'd0, rf_regWrite}, 32'd1);
      check_eq("w_wreg", {27'd0, rf_write_reg}, 32'd5);
      check_eq("w_wdata", rf_write_data, 32'hDEAD_BEEF);
      check_eq("w_busy", {31'd0, busy}, 32'd1);
      check_eq("w_rdy_busy", {31'd0, req0_ready}, 32'd0);
      step();
      @(negedge clk);
      check_eq("w_cnt", {28'd0, wr_count}, 32'd1);
      check_eq("w_idle", {31'd0, busy}, 32'd0);
      check_eq("w_we_off", {31'd0, rf_regWrite}, 32'd0);
      check_eq("w_hold", {27'd0, rf_write_reg}, 32'd5);

      // Both valid continuously: grants alternate 0,1,0,1 starting after reset.
      do_reset();
      @(negedge clk);
      check_eq("rr_cnt0", {28'd0, wr_count}, 32'd0);
      step();
      req0_valid = 1'b1; req0_reg = 5'd10; req0_data = 32'hA0A0_A0A0; req0_byte = 1'b0;
      req1_valid = 1'b1; req1_reg = 5'd11; req1_data = 32'hB1B1_B1B1; req1_byte = 1'b0;
      g = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k % 2 == 0) begin
            g = (k / 2) % 2;
            check_eq("rr_rdy0", {31'd0, req0_ready}, (g == 0) ? 32'd1 : 32'd0);
            check_eq("rr_rdy1", {31'd0, req1_ready}, (g == 1) ? 32'd1 : 32'd0);
         end else begin
            check_eq("rr_gap0", {31'd0, req0_ready | req1_ready}, 32'd0);
            check_eq("rr_we", {31'd0, rf_regWrite}, 32'd1);
            check_eq("rr_wreg", {27'd0, rf_write_reg}, (g == 1) ? 32'd11 : 32'd10);
            check_eq("rr_wdata", rf_write_data, (g == 1) ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0);
         end
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      check_eq("rr_cnt", {28'd0, wr_count}, 32'd4);

      // Byte write of 0xAB to r7 (r7 holds 0x12345678) by req1.
      step();
      req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'hFFFF_FFAB; req1_byte = 1'b1;
      @(negedge clk);
      check_eq("b_rdy1", {31'd0, req1_ready}, 32'd1);
      check_eq("b_rdy0", {31'd0, req0_ready}, 32'd0);
      step(); req1_valid = 1'b0;
      @(negedge clk);
`ifdef REGSEQ_BYTE_RMW_EN
      check_eq("b_rreg", {27'd0, rf_read_reg}, 32'd7);
      check_eq("b_rd_busy", {31'd0, busy}, 32'd1);
      check_eq("b_rd_we", {31'd0, rf_regWrite}, 32'd0);
      step();
      @(negedge clk);
      check_eq("b_we", {31'd0, rf_regWrite}, 32'd1);
      check_eq("b_wreg", {27'd0, rf_write_reg}, 32'd7);
      check_eq("b_wdata", rf_write_data, 32'h1234_56AB);
`else
      check_eq("b_rreg", {27'd0, rf_read_reg}, 32'd0);
      check_eq("b_we", {31'd0, rf_regWrite}, 32'd1);
      check_eq("b_wreg", {27'd0, rf_write_reg}, 32'd7);
      check_eq("b_wdata", rf_write_data, 32'h0000_00AB);
`endif
      step();
      @(negedge clk);
      check_eq("b_idle", {31'd0, busy}, 32'd0);
      check_eq("b_rreg0", {27'd0, rf_read_reg}, 32'd0);
      check_eq("b_cnt", {28'd0, wr_count}, 32'd5);

      // Write to r0 is accepted but suppressed and not counted.
      step();
      req0_valid = 1'b1; req0_reg = 5'd0; req0_data = 32'hFFFF_FFFF; req0_byte = 1'b0;
      @(negedge clk);
      check_eq("z_rdy0", {31'd0, req0_ready}, 32'd1);
      step(); req0_valid = 1'b0;
      @(negedge clk);
      check_eq("z_we", {31'd0, rf_regWrite}, 32'd0);
      check_eq("z_busy", {31'd0, busy}, 32'd1);
      step();
      @(negedge clk);
      check_eq("z_cnt", {28'd0, wr_count}, 32'd5);

      // Reset during the cycle after a byte handshake (READ, or WRITE without RMW).
      step();
      req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'h0000_0055; req0_byte = 1'b1;
      @(negedge clk);
      check_eq("a_rdy0", {31'd0, req0_ready}, 32'd1);
      step(); req0_valid = 1'b0;
      @(negedge clk);
      check_eq("a_busy", {31'd0, busy}, 32'd1);
      #1;
      reset_n = 1'b0;
      req0_valid = 1'b1; req0_reg = 5'd12; req0_data = 32'h0C0C_0C0C; req0_byte = 1'b0;
      req1_valid = 1'b1; req1_reg = 5'd13; req1_data = 32'h0D0D_0D0D; req1_byte = 1'b0;
      #1;
      check_eq("a_we", {31'd0, rf_regWrite}, 32'd0);
      check_eq("a_busy0", {31'd0, busy}, 32'd0);
      check_eq("a_rreg", {27'd0, rf_read_reg}, 32'd0);
      check_eq("a_wreg", {27'd0, rf_write_reg}, 32'd0);
      check_eq("a_wdata", rf_write_data, 32'd0);
      check_eq("a_cnt", {28'd0, wr_count}, 32'd0);
      check_eq("a_rdy_rst", {31'd0, req0_ready | req1_ready}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("a_tie0", {31'd0, req0_ready}, 32'd1);
      check_eq("a_tie1", {31'd0, req1_ready}, 32'd0);
      step(); req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      check_eq("a_wreg12", {27'd0, rf_write_reg}, 32'd12);
      check_eq("a_r9_kept", regs[9], 32'd0);
      step();

      // Counter wrap with CNT_W=4: 16 writes give 0, the 17th gives 1.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         req0_valid = 1'b1; req0_reg = 5'd1; req0_data = i; req0_byte = 1'b0;
         @(negedge clk);
         step(); req0_valid = 1'b0;
         @(negedge clk);
         step();
         if (i == 15) begin
            @(negedge clk);
            check_eq("cnt_wrap", {28'd0, wr_count}, 32'd0);
         end
      end
      @(negedge clk);
      check_eq("cnt_17", {28'd0, wr_count}, 32'd1);
      check_eq("cnt_r1", regs[1], 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_port_sequencer.md
# regfile_port_sequencer

Sequences the shared register-file port between two write-back requesters: the execute stage (requester 0) and the load unit (requester 1). It arbitrates round-robin, registers the winning request, and drives the register file's single write port. It also drives one read port so that byte writes become read-modify-write sequences. It sits between the pipeline write-back stage and the register block.

## Interface

Parameters:
- `ADDR_W`, default 5: register index width (32 registers).
- `DATA_W`, default 32: register width.
- `CNT_W`, default 16: width of the completed-write counter.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: execute stage has a write-back.
- `req0_ready` out 1: request accepted this cycle when valid and ready are both high.
- `req0_reg` in ADDR_W: destination register.
- `req0_data` in DATA_W: write data.
- `req0_byte` in 1: byte operation; only `data[7:0]` is significant.
- `req1_valid`, `req1_ready`, `req1_reg`, `req1_data`, `req1_byte`: same as requester 0, for the load unit.
- `rf_read_reg` out ADDR_W: read index to register block read port 2.
- `rf_read_data` in DATA_W: combinational read result from register block.
- `rf_write_reg` out ADDR_W: register block write index.
- `rf_write_data` out DATA_W: register block write data.
- `rf_regWrite` out 1: register block write strobe.
- `busy` out 1: high whenever state is not IDLE.
- `wr_count` out CNT_W: number of completed register writes; wraps modulo 2^CNT_W.

## Operation

- States: IDLE, READ, WRITE.
- **IDLE**
  - Readies are asserted only here, and at most one at a time.
  - If exactly one requester is valid, that requester gets ready.
  - If both are valid, the requester that was not granted last gets ready. The round-robin pointer `last_grant` resets to 1, so requester 0 wins the first tie.
  - On handshake, latch the request (`reg`, `data`, `byte`, grant id) and update `last_grant`.
  - Next state is READ if the byte flag is set and `BYTE_RMW_EN` is defined; otherwise WRITE.
- **READ** (one cycle)
  - `rf_read_reg` = latched reg.
  - At the clock edge, the merged word is captured: `{rf_read_data[31:8], latched_data[7:0]}`.
  - Next state is WRITE.
- **WRITE** (one cycle)
  - `rf_write_reg` and `rf_write_data` come from registered values.
  - `rf_regWrite` = 1, unless the latched reg is 0. Writes to register 0 are accepted but suppressed and not counted.
  - `wr_count` increments when `rf_regWrite` is 1.
  - Next state is IDLE.
- Word (non-byte) requests write `data` unchanged.
- `rf_read_reg` is 0 outside READ.
- `rf_write_reg` and `rf_write_data` hold their last values outside WRITE; `rf_regWrite` is 0 outside WRITE.
- A requester that is not granted must hold its request stable until it gets ready. The block does not buffer more than one request.

## Timing

- Reset values:
  - state = IDLE, `last_grant` = 1.
  - `req0_ready` = `req1_ready` = 0 while reset is asserted.
  - `rf_read_reg` = 0, `rf_write_reg` = 0, `rf_write_data` = 0, `rf_regWrite` = 0.
  - `busy` = 0, `wr_count` = 0.
- Readies are combinational from state, valids and `last_grant`. They are never high in READ or WRITE.
- Word write:
  - Handshake in cycle N; `rf_regWrite` high in cycle N+1; IDLE again in N+2.
  - Throughput is one word write per 2 cycles.
- Byte write (RMW):
  - Handshake in N; READ in N+1; `rf_regWrite` in N+2; IDLE in N+3.
- Both requesters continuously valid: grants alternate 0, 1, 0, 1, …
- Reset mid-sequence (READ or WRITE):
  - Abort immediately; no write is issued and `wr_count` is cleared.
  - The in-flight request is lost. The requester has already seen its handshake, so recovery is the pipeline's responsibility.
- `wr_count` wraps from 2^CNT_W−1 to 0.

## Configuration

- Macro: `REGSEQ_BYTE_RMW_EN`.
- Defined: byte requests run IDLE→READ→WRITE and preserve bits [31:8] of the destination register.
- Undefined:
  - The READ state and the `rf_read_data` capture logic are compiled out, and `rf_read_reg` is tied to 0.
  - Byte requests go straight to WRITE with the zero-extended value `{24'b0, data[7:0]}`.

## Test plan

- Reset, then `req0` word write of 0xDEADBEEF to r5. Required: ready in cycle 1, `rf_regWrite`=1 with r5/0xDEADBEEF in cycle 2, `wr_count`=1.
- Both requesters valid continuously with distinct regs. Required: grant order req0, req1, req0, req1, with exactly one ready at a time and a handshake every 2 cycles.
- With RMW enabled, r7 holds 0x12345678 and `req1` byte-writes 0xAB to r7. Required: `rf_read_reg`=7 in the READ cycle, then a write of 0x123456AB; the same test with the macro undefined writes 0x000000AB.
- Write to r0 with data 0xFFFFFFFF. Required: handshake completes, `rf_regWrite` stays 0, `wr_count` is unchanged.
- Assert `reset_n` low during a READ cycle. Required: no `rf_regWrite` pulse, all outputs at reset values, and the first tie after release is granted to req0.
- With `CNT_W`=4, perform 17 writes. Required: `wr_count`=1.
